vga_out_buffer: RTL

Elastic output stage between the 3x3 convolution stage and the VGA RGB pins. Accepts convolution pixels over the valid/ready handshake into a small FIFO and releases exactly one pixel per visible VGA cycle, aligned to the frame start. It detects starvation and frame misalignment, blanks the output, and resynchronises on the next start-of-packet.

---
 rtl/vga_out_buffer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/vga_out_buffer.sv
// Elastic FIFO between the convolution stage and the VGA pins; releases one pixel per visible cycle.
// Optional error counter enabled by defining VGA_OUT_ERR_COUNT_EN.
module vga_out_buffer #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              startofpacket_in,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic              frame_start,
    input  logic              visible,
    output logic [DATA_W-1:0] pix_out,
    output logic              pix_valid,
    output logic              in_sync
`ifdef VGA_OUT_ERR_COUNT_EN
    ,
    output logic [15:0]       err_count
`endif
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int NPIX = IMG_W * IMG_H;
    localparam int PCW  = (NPIX > 1) ? $clog2(NPIX) : 1;

    localparam logic [1:0] ST_SEEK  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [DATA_W:0]   mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]     count_r, count_nx;
    logic              ready_r;
    logic [1:0]        state_r, state_nx;
    logic [PCW-1:0]    pcnt_r, pcnt_nx;
    logic [DATA_W-1:0] pix_r;
    logic              pix_valid_r, in_sync_r;

    logic [DATA_W:0]   head_s;
    logic              head_sop_s, empty_s, wr_s, pop_s, out_s, err_s;

    // Head decode, FSM next state and pop/output strobes
    always_comb begin
        head_s     = mem_r[rd_ptr_r];
        head_sop_s = head_s[DATA_W];
        empty_s    = (count_r == CW'(0));
        wr_s       = valid_in && ready_r;
        pop_s      = 1'b0;
        out_s      = 1'b0;
        err_s      = 1'b0;
        state_nx   = state_r;
        pcnt_nx    = pcnt_r;
        case (state_r)
            ST_SEEK: begin
                if (!empty_s && head_sop_s) begin
                    state_nx = ST_ARMED;
                end else if (!empty_s) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            ST_ARMED: begin
                if (frame_start) begin
                    state_nx = ST_RUN;
                    pcnt_nx  = {PCW{1'b0}};
                end else begin
                    state_nx = ST_ARMED;
                end
            end
            ST_RUN: begin
                // Underflow and both desync forms collapse into a single error event
                err_s = (visible && empty_s) ||
                        ((pcnt_r != PCW'(0)) &&
                         (frame_start || (visible && !empty_s && head_sop_s)));
                if (err_s) begin
                    state_nx = ST_SEEK;
                    pcnt_nx  = {PCW{1'b0}};
                end else if (visible) begin
                    pop_s = 1'b1;
                    out_s = 1'b1;
                    if (pcnt_r == PCW'(NPIX - 1)) begin
                        state_nx = ST_SEEK;
                        pcnt_nx  = {PCW{1'b0}};
                    end else begin
                        pcnt_nx = pcnt_r + PCW'(1);
                    end
                end else begin
                    state_nx = ST_RUN;
                end
            end
            default: begin
                state_nx = ST_SEEK;
                pcnt_nx  = {PCW{1'b0}};
            end
        endcase
        case ({wr_s, pop_s})
            2'b10:   count_nx = count_r + CW'(1);
            2'b01:   count_nx = count_r - CW'(1);
            default: count_nx = count_r;
        endcase
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= {startofpacket_in, data_in};
        end
    end

    // FIFO pointers, occupancy and registered ready
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            ready_r  <= 1'b0;
        end else begin
            if (wr_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
            count_r <= count_nx;
            ready_r <= (count_nx != CW'(DEPTH));
        end
    end

    // FSM state, pixel counter and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_SEEK;
            pcnt_r      <= {PCW{1'b0}};
            pix_r       <= {DATA_W{1'b0}};
            pix_valid_r <= 1'b0;
            in_sync_r   <= 1'b0;
        end else begin
            state_r     <= state_nx;
            pcnt_r      <= pcnt_nx;
            pix_r       <= out_s ? head_s[DATA_W-1:0] : {DATA_W{1'b0}};
            pix_valid_r <= out_s;
            in_sync_r   <= (state_nx == ST_RUN);
        end
    end

`ifdef VGA_OUT_ERR_COUNT_EN
    logic [15:0] err_cnt_r;

    // Saturating error event counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_r <= 16'd0;
        end else if (err_s && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'd1;
        end
    end

    assign err_count = err_cnt_r;
`endif

    assign ready_out = ready_r;
    assign pix_out   = pix_r;
    assign pix_valid = pix_valid_r;
    assign in_sync   = in_sync_r;

endmodule
